wbc_arbiter: RTL
================

# wbc_arbiter

Round-robin arbiter for the shared WISHBONE control bus (20-bit address, 32-bit data). It arbitrates between four control masters: PCI bridge, TURFbus, housekeeping, and the debug VIO. It drives one registered-grant master port into the slave-side interconnect/decoder. A bus watchdog terminates any transfer a slave never acknowledges, so a hung slave cannot lock out the PCI host.

## Interface
Parameters:
- NM, 4: number of masters; index 0 = pcic, 1 = turfc, 2 = hkmc, 3 = wbvio.
- TIMEOUT, 1023: cycles a strobed transfer may wait for ack/err/rty before abort (1..65535).

Ports:
- clk_i  in  1  control bus clock (wbc_clk).
- rst_neg_i  in  1  reset; asynchronous, active-low.
- m_cyc_i  in  NM  per-master CYC.
- m_stb_i  in  NM  per-master STB.
- m_we_i  in  NM  per-master WE.
- m_adr_i  in  20*NM  per-master address; master k at [20k +: 20].
- m_dat_i  in  32*NM  per-master write data; master k at [32k +: 32].
- m_sel_i  in  4*NM  per-master byte select; master k at [4k +: 4].
- m_ack_o  out  NM  per-master ACK.
- m_err_o  out  NM  per-master ERR.
- m_rty_o  out  NM  per-master RTY.
- m_dat_o  out  32  read data, shared by all masters.
- s_cyc_o  out  1  slave-side CYC.
- s_stb_o  out  1  slave-side STB.
- s_we_o  out  1  slave-side WE.
- s_adr_o  out  20  slave-side address.
- s_dat_o  out  32  slave-side write data.
- s_sel_o  out  4  slave-side byte select.
- s_ack_i  in  1  slave ACK.
- s_err_i  in  1  slave ERR.
- s_rty_i  in  1  slave RTY.
- s_dat_i  in  32  slave read data.
- grant_o  out  NM  registered one-hot grant; zero when idle.
- timeout_count_o  out  8  saturating count of watchdog aborts.

## Operation
- States: IDLE, BUSY, ABORT.
- IDLE
  - Sample m_cyc_i.
  - If any master requests, grant the first requester searching upward from (last+1) mod NM, wrapping.
  - Register grant_o and go to BUSY.
  - `last` resets to NM-1, so master 0 wins the first contention.
- BUSY
  - s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o and s_sel_o are a combinational mux of the granted master's signals, selected by the registered grant.
  - m_ack_o, m_err_o and m_rty_o for the granted master pass through combinationally from the slave; for all other masters they are 0.
  - m_dat_o = s_dat_i unconditionally.
  - Grant is held for the whole CYC, so burst and read-modify-write cycles are never split.
  - When the granted master deasserts m_cyc_i: clear grant_o, set `last` to the granted index, return to IDLE.
- Watchdog
  - The counter clears on any cycle where stb is low or s_ack_i, s_err_i or s_rty_i is high.
  - Otherwise it increments while s_stb_o is high.
  - When it reaches TIMEOUT-1 with no termination, go to ABORT.
- ABORT
  - Force s_cyc_o = s_stb_o = 0.
  - Assert m_err_o of the granted master for exactly the first ABORT cycle.
  - Increment timeout_count_o, saturating at 255.
  - Stay in ABORT until the granted master drops cyc, then clear grant, update `last`, return to IDLE.
  - Slave ack/err/rty arriving in ABORT is ignored.
- Simultaneous events
  - A slave termination in the same cycle the counter reaches TIMEOUT-1 wins: normal pass-through, no abort.
  - Requests arriving during BUSY or ABORT wait; no preemption.
- Reset
  - rst_neg_i low asynchronously forces IDLE, grant_o = 0, counter = 0, timeout_count_o = 0, `last` = NM-1.
  - All s_* control outputs and all m_ack_o, m_err_o and m_rty_o go to 0 immediately, including mid-transfer.
- Only lowest 16 bits of counter exist; TIMEOUT outside 1..65535 is unsupported.

## Timing
- Reset values: grant_o = 0; s_cyc_o = s_stb_o = s_we_o = 0; s_adr_o, s_dat_o, s_sel_o = 0 while idle (mux gated by grant); m_ack_o, m_err_o, m_rty_o = 0; timeout_count_o = 0.
- Grant latency: m_cyc_i rising, sampled at edge N, gives grant_o and s_cyc_o high after edge N.
  - A zero-wait slave can ack in that same cycle, so minimum transfer is 2 cycles from request.
- Release: m_cyc_i low sampled at edge M, grant_o = 0 after edge M.
  - There is one mandatory IDLE cycle between grants, so the earliest next grant is after edge M+1.
- Ack path: combinational s_ack_i to m_ack_o, zero latency.
- Abort: m_err_o asserts in the cycle after the edge at which the counter equals TIMEOUT-1, i.e. TIMEOUT cycles after stb with no termination.

## Test plan
- Single master: master 1 does a read; slave acks 2 cycles after s_stb_o.
  - grant_o = 4'b0010 one cycle after cyc.
  - m_ack_o = 4'b0010 coincides with s_ack_i.
  - m_dat_o = 32'hDEADBEEF from s_dat_i.
- Round-robin: all four masters hold cyc continuously, each does one single-beat transfer and drops cyc.
  - Grant order is 0,1,2,3,0, with exactly one idle cycle between each.
- Hold: master 2 runs a 4-beat CYC with stb toggling; master 0 requests in the middle.
  - grant_o stays 4'b0100 until master 2 drops cyc, then goes to 4'b0001.
- Watchdog: TIMEOUT = 16, slave never acks.
  - m_err_o of the granted master pulses one cycle, 16 cycles after stb.
  - s_cyc_o drops; timeout_count_o goes 0 to 1.
  - Repeat 300 times: timeout_count_o saturates at 255.
- Race: s_ack_i arrives exactly on the terminal count cycle.
  - m_ack_o is asserted, no m_err_o, timeout_count_o unchanged.
- Reset mid-transfer: assert rst_neg_i low while in BUSY.
  - grant_o, s_cyc_o and m_ack_o go to 0 without a clock edge.
  - After release, master 0 wins first contention against master 3.

Source files
------------

// File: rtl/wbc_arbiter.sv
// wbc_arbiter: round-robin arbiter for the shared WISHBONE control bus.
// Four control masters (pcic, turfc, hkmc, wbvio) share one slave-side port.
// A grant is held for the whole CYC. A watchdog aborts any strobed transfer
// that no slave terminates, so a hung slave cannot lock out the PCI host.
module wbc_arbiter #(
    parameter int NM      = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk_i,
    input  logic             rst_neg_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [20*NM-1:0] m_adr_i,
    input  logic [32*NM-1:0] m_dat_i,
    input  logic [4*NM-1:0]  m_sel_i,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NM-1:0]    m_rty_o,
    output logic [31:0]      m_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [19:0]      s_adr_o,
    output logic [31:0]      s_dat_o,
    output logic [3:0]       s_sel_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    input  logic [31:0]      s_dat_i,
    output logic [NM-1:0]    grant_o,
    output logic [7:0]       timeout_count_o
);

    localparam int          IW      = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t          state, state_nxt;
    logic [NM-1:0]   grant, grant_nxt;
    logic [IW-1:0]   cur, cur_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [15:0]     wd_cnt, wd_cnt_nxt;
    logic            abort_first, abort_first_nxt;
    logic [7:0]      tcnt, tcnt_nxt;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [NM-1:0]   pick_grant;

    logic            sel_cyc, sel_stb, sel_we;
    logic [19:0]     sel_adr;
    logic [31:0]     sel_dat;
    logic [3:0]      sel_sel;
    logic            term;
    logic            wd_hit;

    // Round-robin search: first requester at or above (last+1) mod NM.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_grant = '0;
        for (int i = 1; i <= NM; i++) begin
            if (!pick_valid && m_cyc_i[(int'(last) + i) % NM]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'((int'(last) + i) % NM);
            end
        end
        for (int k = 0; k < NM; k++) begin
            pick_grant[k] = pick_valid && (k == int'(pick_idx));
        end
    end

    // AND-OR mux of the granted master's request; all zero when no grant is held.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        sel_sel = '0;
        for (int k = 0; k < NM; k++) begin
            if (grant[k]) begin
                sel_cyc = sel_cyc | m_cyc_i[k];
                sel_stb = sel_stb | m_stb_i[k];
                sel_we  = sel_we  | m_we_i[k];
                sel_adr = sel_adr | m_adr_i[20*k +: 20];
                sel_dat = sel_dat | m_dat_i[32*k +: 32];
                sel_sel = sel_sel | m_sel_i[4*k +: 4];
            end
        end
    end

    // Slave-side drive and master-side responses. Everything is gated by the
    // registered grant/state, so an asynchronous reset silences the bus at once.
    always_comb begin
        term    = s_ack_i | s_err_i | s_rty_i;
        s_cyc_o = (state == BUSY) && sel_cyc;
        s_stb_o = (state == BUSY) && sel_cyc && sel_stb;
        s_we_o  = sel_we;
        s_adr_o = sel_adr;
        s_dat_o = sel_dat;
        s_sel_o = sel_sel;
        m_dat_o = s_dat_i;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state == BUSY) begin
            m_ack_o = grant & {NM{s_ack_i}};
            m_err_o = grant & {NM{s_err_i}};
            m_rty_o = grant & {NM{s_rty_i}};
        end else if (state == ABORT && abort_first) begin
            m_err_o = grant;
        end
        // A termination on the terminal-count cycle wins over the abort.
        wd_hit  = s_stb_o && !term && (wd_cnt == WD_LAST);
        grant_o         = grant;
        timeout_count_o = tcnt;
    end

    // Next-state logic: arbitration, release, watchdog abort.
    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        cur_nxt         = cur;
        last_nxt        = last;
        tcnt_nxt        = tcnt;
        abort_first_nxt = 1'b0;
        wd_cnt_nxt      = (!s_stb_o || term) ? 16'd0 : wd_cnt + 16'd1;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = BUSY;
                    grant_nxt = pick_grant;
                    cur_nxt   = pick_idx;
                end
            end
            BUSY: begin
                if (!sel_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    last_nxt  = cur;
                end else if (wd_hit) begin
                    state_nxt       = ABORT;
                    abort_first_nxt = 1'b1;
                    if (tcnt != 8'hFF) tcnt_nxt = tcnt + 8'd1;
                end
            end
            ABORT: begin
                if (!sel_cyc) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    last_nxt  = cur;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; `last` resets to NM-1 so master 0 wins the first contention.
    always_ff @(posedge clk_i or negedge rst_neg_i) begin
        if (!rst_neg_i) begin
            state       <= IDLE;
            grant       <= '0;
            cur         <= '0;
            last        <= IW'(NM - 1);
            wd_cnt      <= '0;
            abort_first <= 1'b0;
            tcnt        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state       <= state_nxt;
            grant       <= grant_nxt;
            cur         <= cur_nxt;
            last        <= last_nxt;
            wd_cnt      <= wd_cnt_nxt;
            abort_first <= abort_first_nxt;
            tcnt        <= tcnt_nxt;
        end
    end

endmodule
